// File: rtl/red_pitaya_na_sweep_ctrl.sv
// Network-analyzer sweep sequencer: steps the IQ frequency, waits for each
// averaging series, and queues the four quadrature-sum words per point for the PS.
module red_pitaya_na_sweep_ctrl #(
   parameter int unsigned PTSZ         = 4,
   parameter logic [15:0] IQ_FREQ_ADDR = 16'h108,
   parameter logic [15:0] IQ_SUM_ADDR  = 16'h140
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [15:0] addr,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic [15:0] m_addr,
   output logic        m_wen,
   output logic        m_ren,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack
);

   localparam int unsigned DEPTH = 2 ** PTSZ;
   localparam int unsigned CW    = PTSZ + 1;
   localparam int unsigned PW    = 128;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_FREQ, S_POLL, S_RD1, S_RD2, S_RD3, S_PUSH
   } state_t;

   state_t          state;
   logic [31:0]     start_freq, step_freq, num_points, points_done, freq;
   logic [31:0]     word0, word1, word2, word3;
   logic [PW-1:0]   mem [DEPTH];
   logic [CW-1:0]   wr_ptr, rd_ptr;

   logic [CW-1:0]   count_c;
   logic [PW-1:0]   head_c;
   logic [31:0]     next_freq_c, rd_mux_c;
   logic            ctrl_wr_c, start_c, abort_c;
   logic            empty_c, full_c, busy_c, push_c, pop_c;

   assign ctrl_wr_c   = wen && (addr == 16'h000);
   assign start_c     = ctrl_wr_c && wdata[0];
   assign abort_c     = ctrl_wr_c && wdata[1];
   assign count_c     = wr_ptr - rd_ptr;
   assign empty_c     = (count_c == '0);
   assign full_c      = (count_c == CW'(DEPTH));
   assign busy_c      = (state != S_IDLE);
   assign push_c      = (state == S_PUSH) && !full_c && !abort_c;
   assign pop_c       = ren && (addr == 16'h02C) && !empty_c;
   assign head_c      = mem[rd_ptr[PTSZ-1:0]];
   assign next_freq_c = freq + step_freq;

   // Slave read mux; FIFO head words read as zero while empty
   always_comb begin
      rd_mux_c = '0;
      case (addr)
         16'h000: rd_mux_c = {28'b0, 1'b0, empty_c, full_c, busy_c};
         16'h004: rd_mux_c = start_freq;
         16'h008: rd_mux_c = step_freq;
         16'h00C: rd_mux_c = num_points;
         16'h010: rd_mux_c = points_done;
         16'h014: rd_mux_c = 32'(count_c);
         16'h020: rd_mux_c = empty_c ? '0 : head_c[31:0];
         16'h024: rd_mux_c = empty_c ? '0 : head_c[63:32];
         16'h028: rd_mux_c = empty_c ? '0 : head_c[95:64];
         16'h02C: rd_mux_c = empty_c ? '0 : head_c[127:96];
         default: rd_mux_c = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ack        <= 1'b0;
         rdata      <= '0;
         start_freq <= '0;
         step_freq  <= '0;
         num_points <= '0;
      end else begin
         ack   <= wen || ren;
         rdata <= ren ? rd_mux_c : '0;
         if (wen) begin
            case (addr)
               16'h004: start_freq <= wdata;
               16'h008: step_freq  <= wdata;
               16'h00C: num_points <= wdata;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_c) mem[wr_ptr[PTSZ-1:0]] <= {word3, word2, word1, word0};
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + CW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + CW'(1);
      end
   end

   // Sequencer: each request is launched on the edge that retires the previous one
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state       <= S_IDLE;
         m_wen       <= 1'b0;
         m_ren       <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         freq        <= '0;
         points_done <= '0;
         word0       <= '0;
         word1       <= '0;
         word2       <= '0;
         word3       <= '0;
      end else begin
         m_wen <= 1'b0;
         m_ren <= 1'b0;
         if (abort_c) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_c && (num_points != '0)) begin
                     freq        <= start_freq;
                     points_done <= '0;
                     m_wen       <= 1'b1;
                     m_addr      <= IQ_FREQ_ADDR;
                     m_wdata     <= start_freq;
                     state       <= S_WR_FREQ;
                  end
               end
               S_WR_FREQ: begin
                  if (m_ack) begin
                     m_ren  <= 1'b1;
                     m_addr <= IQ_SUM_ADDR;
                     state  <= S_POLL;
                  end
               end
               S_POLL: begin
                  if (m_ack) begin
                     m_ren <= 1'b1;
                     if (!m_rdata[31]) begin
                        word0  <= m_rdata;
                        m_addr <= IQ_SUM_ADDR + 16'd4;
                        state  <= S_RD1;
                     end
                  end
               end
               S_RD1: begin
                  if (m_ack) begin
                     word1  <= m_rdata;
                     m_ren  <= 1'b1;
                     m_addr <= IQ_SUM_ADDR + 16'd8;
                     state  <= S_RD2;
                  end
               end
               S_RD2: begin
                  if (m_ack) begin
                     word2  <= m_rdata;
                     m_ren  <= 1'b1;
                     m_addr <= IQ_SUM_ADDR + 16'd12;
                     state  <= S_RD3;
                  end
               end
               S_RD3: begin
                  if (m_ack) begin
                     word3 <= m_rdata;
                     state <= S_PUSH;
                  end
               end
               S_PUSH: begin
                  if (!full_c) begin
                     points_done <= points_done + 32'd1;
                     freq        <= next_freq_c;
                     if ((points_done + 32'd1) == num_points) begin
                        state <= S_IDLE;
                     end else begin
                        m_wen   <= 1'b1;
                        m_addr  <= IQ_FREQ_ADDR;
                        m_wdata <= next_freq_c;
                        state   <= S_WR_FREQ;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_red_pitaya_na_sweep_ctrl.sv
// Directed bench for the sweep sequencer with a one-cycle-ack IQ register model.
module tb_red_pitaya_na_sweep_ctrl;

   logic        clk    = 1'b0;
   logic        rstn_i = 1'b0;
   logic [15:0] addr   = '0;
   logic        wen    = 1'b0;
   logic        ren    = 1'b0;
   logic [31:0] wdata  = '0;
   logic        ack;
   logic [31:0] rdata;
   logic [15:0] m_addr;
   logic        m_wen, m_ren;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic        m_ack   = 1'b0;

   int checks = 0;
   int errors = 0;

   // IQ model configuration (written by the stimulus only)
   logic [31:0] d0 = 32'd5, d1 = 32'd4, d2 = 32'h7FFF_FFFF, d3 = 32'h7FFF_FFFF;
   logic        use_freq  = 1'b1;
   logic [31:0] hang_freq = 32'hFFFF_FFFF;
   int          busy_polls = 5;

   // IQ model state (written by the model only)
   logic [31:0] wr_log [128];
   int          wr_cnt = 0, pulses = 0, bad = 0, viol = 0, polls = 0;
   logic        outst = 1'b0;
   logic [31:0] last_freq = '0;
   int          wr_base;

   red_pitaya_na_sweep_ctrl dut (
      .clk_i(clk), .rstn_i(rstn_i), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
      .ack(ack), .rdata(rdata), .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_wen || m_ren) begin
         pulses <= pulses + 1;
         if (outst || (m_wen && m_ren)) viol <= viol + 1;
         outst <= 1'b1;
         m_ack <= 1'b1;
         if (m_wen) begin
            if (m_addr != 16'h108) bad <= bad + 1;
            if (wr_cnt < 128) wr_log[wr_cnt] <= m_wdata;
            wr_cnt    <= wr_cnt + 1;
            last_freq <= m_wdata;
            polls     <= 0;
            m_rdata   <= '0;
         end else begin
            case (m_addr)
               16'h140: begin
                  polls <= polls + 1;
                  if (polls < busy_polls || last_freq == hang_freq) m_rdata <= 32'h8000_0000;
                  else m_rdata <= use_freq ? {1'b0, last_freq[30:0]} : d0;
               end
               16'h144: m_rdata <= d1;
               16'h148: m_rdata <= d2;
               16'h14C: m_rdata <= d3;
               default: begin bad <= bad + 1; m_rdata <= '0; end
            endcase
         end
      end else begin
         m_ack <= 1'b0;
         if (m_ack) outst <= 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Bus tasks start and end on a negedge so consecutive calls are back-to-back
   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
      addr = a; wdata = d; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
      addr = a; ren = 1'b1;
      @(negedge clk);
      ren = 1'b0;
      d = rdata;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      chk(tag, d, exp);
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] d;
      int n = 0;
      do begin bus_rd(16'h000, d); n++; end while (d[0] && n < 3000);
      chk(tag, 32'(d[0]), 32'd0);
   endtask

   task automatic cfg(input logic [31:0] sf, input logic [31:0] st, input logic [31:0] np);
      bus_wr(16'h004, sf);
      bus_wr(16'h008, st);
      bus_wr(16'h00C, np);
   endtask

   initial begin
      logic [31:0] d;
      int n, k, snap;

      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_m_wen", 32'(m_wen), 0);
      chk("rst_m_ren", 32'(m_ren), 0);
      chk("rst_m_addr", 32'(m_addr), 0);
      chk("rst_m_wdata", m_wdata, 0);
      rstn_i = 1'b1;
      @(negedge clk);
      rd_chk("rst_ctrl", 16'h000, 32'h4);
      chk("rd_ack", 32'(ack), 1);
      rd_chk("rst_count", 16'h014, 0);
      rd_chk("rst_numpts", 16'h00C, 0);

      // Basic sweep
      wr_base = wr_cnt;
      cfg(32'd1000, 32'd10, 32'd3);
      rd_chk("numpts_rb", 16'h00C, 32'd3);
      bus_wr(16'h000, 32'h1);
      wait_idle("basic_idle");
      chk("basic_wrcnt", 32'(wr_cnt - wr_base), 3);
      chk("basic_f0", wr_log[wr_base], 32'd1000);
      chk("basic_f1", wr_log[wr_base + 1], 32'd1010);
      chk("basic_f2", wr_log[wr_base + 2], 32'd1020);
      rd_chk("basic_count", 16'h014, 3);
      rd_chk("basic_done", 16'h010, 3);
      rd_chk("basic_ctrl", 16'h000, 0);
      for (int i = 0; i < 3; i++) begin
         rd_chk("basic_ilo", 16'h020, 32'(1000 + 10 * i));
         rd_chk("basic_ihi", 16'h024, 32'd4);
         rd_chk("basic_qlo", 16'h028, 32'h7FFF_FFFF);
         rd_chk("basic_qhi", 16'h02C, 32'h7FFF_FFFF);
      end
      rd_chk("basic_ctrl_empty", 16'h000, 32'h4);

      // Data capture with fixed sums
      use_freq = 1'b0;
      cfg(32'd2000, 32'd10, 32'd1);
      bus_wr(16'h000, 32'h1);
      wait_idle("data_idle");
      rd_chk("data_count", 16'h014, 1);
      rd_chk("data_ilo", 16'h020, 32'd5);
      rd_chk("data_ihi", 16'h024, 32'd4);
      rd_chk("data_qlo", 16'h028, 32'h7FFF_FFFF);
      rd_chk("data_count_nopop", 16'h014, 1);
      rd_chk("data_qhi", 16'h02C, 32'h7FFF_FFFF);
      rd_chk("data_count_pop", 16'h014, 0);
      rd_chk("empty_pop", 16'h02C, 0);
      rd_chk("empty_ilo", 16'h020, 0);
      rd_chk("empty_count", 16'h014, 0);
      rd_chk("unmapped", 16'h030, 0);

      // FIFO full stall
      use_freq = 1'b1; busy_polls = 0;
      wr_base = wr_cnt;
      cfg(32'd100, 32'd1, 32'd20);
      bus_wr(16'h000, 32'h1);
      n = 0;
      do begin bus_rd(16'h014, d); n++; end while (d != 32'd16 && n < 1000);
      chk("full_count", d, 16);
      repeat (20) bus_rd(16'h000, d);
      rd_chk("full_ctrl", 16'h000, 32'h3);
      snap = pulses;
      repeat (30) bus_rd(16'h000, d);
      chk("full_no_traffic", 32'(pulses - snap), 0);
      chk("full_wrcnt", 32'(wr_cnt - wr_base), 17);
      chk("full_last_f", wr_log[wr_base + 16], 32'd116);
      rd_chk("full_done", 16'h010, 16);
      rd_chk("full_head", 16'h020, 32'd100);
      bus_rd(16'h02C, d);
      repeat (15) bus_rd(16'h000, d);
      chk("resume_wrcnt", 32'(wr_cnt - wr_base), 18);
      chk("resume_f", wr_log[wr_base + 17], 32'd117);
      k = 1; n = 0;
      while (k < 20 && n < 3000) begin
         bus_rd(16'h014, d); n++;
         if (d != 0) begin
            rd_chk("drain_head", 16'h020, 32'(100 + k));
            bus_rd(16'h02C, d);
            k++;
         end
      end
      chk("drain_all", 32'(k), 20);
      wait_idle("full_idle");
      rd_chk("full_done_end", 16'h010, 20);
      rd_chk("full_count_end", 16'h014, 0);

      // Pops sweeping across every phase of the push cycle
      cfg(32'd100, 32'd1, 32'd20);
      bus_wr(16'h000, 32'h1);
      n = 0;
      do begin bus_rd(16'h014, d); n++; end while (d < 32'd2 && n < 500);
      for (int i = 0; i < 11; i++) begin
         rd_chk("sim_head", 16'h020, 32'(100 + i));
         repeat (10) bus_rd(16'h000, d);
         bus_rd(16'h02C, d);
      end
      wait_idle("sim_idle");
      rd_chk("sim_count", 16'h014, 9);
      rd_chk("sim_done", 16'h010, 20);

      // Abort during POLL
      hang_freq = 32'd510;
      wr_base = wr_cnt;
      cfg(32'd500, 32'd10, 32'd5);
      bus_wr(16'h000, 32'h1);
      repeat (60) bus_rd(16'h000, d);
      chk("hang_busy", d, 32'h1);
      chk("hang_wrcnt", 32'(wr_cnt - wr_base), 2);
      bus_wr(16'h004, 32'd900);
      bus_wr(16'h000, 32'h1);
      repeat (10) bus_rd(16'h000, d);
      chk("start_busy_ignored", 32'(wr_cnt - wr_base), 2);
      bus_wr(16'h004, 32'd500);
      bus_wr(16'h000, 32'h2);
      chk("abort_m_wen", 32'(m_wen), 0);
      chk("abort_m_ren", 32'(m_ren), 0);
      rd_chk("abort_ctrl", 16'h000, 0);
      snap = pulses;
      repeat (20) bus_rd(16'h000, d);
      chk("abort_no_traffic", 32'(pulses - snap), 0);
      rd_chk("abort_count", 16'h014, 10);
      rd_chk("abort_done", 16'h010, 1);
      bus_wr(16'h000, 32'h3);
      rd_chk("abort_wins", 16'h000, 0);
      chk("abort_wins_wr", 32'(wr_cnt - wr_base), 2);
      hang_freq = 32'hFFFF_FFFF;
      wr_base = wr_cnt;
      bus_wr(16'h000, 32'h1);
      wait_idle("restart_idle");
      chk("restart_wrcnt", 32'(wr_cnt - wr_base), 5);
      chk("restart_f0", wr_log[wr_base], 32'd500);
      chk("restart_f4", wr_log[wr_base + 4], 32'd540);
      rd_chk("restart_count", 16'h014, 15);
      rd_chk("restart_done", 16'h010, 5);
      repeat (15) bus_rd(16'h02C, d);
      rd_chk("restart_drained", 16'h014, 0);

      // num_points = 0 start is ignored
      wr_base = wr_cnt;
      bus_wr(16'h00C, 32'd0);
      bus_wr(16'h000, 32'h1);
      rd_chk("zero_pts_ctrl", 16'h000, 32'h4);
      repeat (5) bus_rd(16'h000, d);
      chk("zero_pts_wr", 32'(wr_cnt - wr_base), 0);

      // Frequency wrap
      cfg(32'hFFFF_FFF0, 32'h20, 32'd2);
      bus_wr(16'h000, 32'h1);
      wait_idle("wrap_idle");
      chk("wrap_f0", wr_log[wr_base], 32'hFFFF_FFF0);
      chk("wrap_f1", wr_log[wr_base + 1], 32'h10);
      rd_chk("wrap_head0", 16'h020, 32'h7FFF_FFF0);
      bus_rd(16'h02C, d);
      rd_chk("wrap_head1", 16'h020, 32'h10);
      bus_rd(16'h02C, d);

      // Reset mid-sweep
      hang_freq = 32'd700;
      cfg(32'd700, 32'd1, 32'd3);
      bus_wr(16'h000, 32'h1);
      repeat (10) bus_rd(16'h000, d);
      rstn_i = 1'b0;
      @(negedge clk);
      rstn_i = 1'b1;
      chk("mid_rst_m_wen", 32'(m_wen), 0);
      chk("mid_rst_m_ren", 32'(m_ren), 0);
      chk("mid_rst_m_addr", 32'(m_addr), 0);
      chk("mid_rst_m_wdata", m_wdata, 0);
      snap = pulses;
      rd_chk("mid_rst_ctrl", 16'h000, 32'h4);
      rd_chk("mid_rst_start", 16'h004, 0);
      rd_chk("mid_rst_done", 16'h010, 0);
      repeat (10) bus_rd(16'h000, d);
      chk("mid_rst_no_traffic", 32'(pulses - snap), 0);

      chk("model_bad_addr", 32'(bad), 0);
      chk("model_protocol", 32'(viol), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
